// File: rtl/nanov_store_capture_pkg.sv
// nanov_store_capture_pkg: shared widths and bit-reversal helper for the store capture block
package nanov_store_capture_pkg;
  localparam int XLEN = 32;
  localparam int EV_W = 2 * XLEN;
  function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction
endpackage

// File: rtl/nanov_store_capture_event_fifo.sv
// nanov_store_capture_event_fifo: first-word fall-through event queue with occupancy count
module nanov_store_capture_event_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/nanov_store_capture.sv
// nanov_store_capture: latches CPU store strobes, decodes an output register window and queues store events
module nanov_store_capture import nanov_store_capture_pkg::*; #(
  parameter int              XLEN         = nanov_store_capture_pkg::XLEN,
  parameter int              DEPTH        = 4,
  parameter int              NUM_REGS     = 4,
  parameter logic [XLEN-1:0] BASE_ADDR    = 'h1000,
  parameter int              REVERSE_DATA = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [XLEN-1:0]            cpu_data,
  input  logic                       store_data_in,
  input  logic                       store_addr_in,
  output logic [XLEN-1:0]            addr,
  output logic [XLEN-1:0]            data,
  output logic [NUM_REGS*XLEN-1:0]   reg_out,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [XLEN-1:0]            ev_addr,
  output logic [XLEN-1:0]            ev_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);
  logic [XLEN-1:0] rev_data, off;
  logic [NUM_REGS-1:0] sel;
  logic full, empty, drop;
  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign rev_data[i] = (REVERSE_DATA != 0) ? cpu_data[XLEN-1-i] : cpu_data[i];
  end
  // An offset of exactly 4*k covers both word alignment and the window bound
  assign off = addr - BASE_ADDR;
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_sel
    assign sel[k] = store_data_in && off == XLEN'(k * 4);
  end
  assign ev_valid = !empty;
  assign drop     = store_data_in && full && !ev_ready;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      addr     <= '0;
      data     <= '0;
      reg_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (store_addr_in && !store_data_in) addr <= cpu_data;
      if (store_data_in) data <= rev_data;
      for (int k = 0; k < NUM_REGS; k++)
        if (sel[k]) reg_out[k*XLEN +: XLEN] <= rev_data;
      overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : overflow;
    end
  nanov_store_capture_event_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (store_data_in),
    .din   ({addr, rev_data}),
    .pop   (ev_ready),
    .dout  ({ev_addr, ev_data}),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );
endmodule
